// File: rtl/ctrlport_spi_arbiter_pkg.sv
// Shared types and constants for the ctrlport-to-SPI bridge arbiter.
// Status codes mirror the rfnoc core ctrlport.vh encoding.
package ctrlport_spi_arbiter_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STS_W  = 2;

  localparam logic [STS_W-1:0] CTRL_STS_OKAY    = 2'b00;
  localparam logic [STS_W-1:0] CTRL_STS_CMDERR  = 2'b01;
  localparam logic [STS_W-1:0] CTRL_STS_TSERR   = 2'b10;
  localparam logic [STS_W-1:0] CTRL_STS_WARNING = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  // Index width that stays legal for a single-port build
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrlport_rr_select.sv
// Combinational round-robin pick: lowest requesting port at or after ptr, wrapping.
module ctrlport_rr_select #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PW        = 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [PW-1:0]        ptr,
  output logic [PW-1:0]        grant,
  output logic                 valid
);

  always_comb begin
    int unsigned idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!valid && (|(pending & (NUM_PORTS'(1) << idx)))) begin
        grant = PW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrlport_spi_arbiter.sv
// Shares one ctrlport-to-SPI bridge among NUM_PORTS requesters, one transaction
// at a time, round-robin, with a response timeout and late-response drain.
module ctrlport_spi_arbiter
  import ctrlport_spi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        ctrlport_clk,
  input  logic                        ctrlport_rst_n,
  input  logic [NUM_PORTS-1:0]        s_ctrlport_req_wr,
  input  logic [NUM_PORTS-1:0]        s_ctrlport_req_rd,
  input  logic [ADDR_W*NUM_PORTS-1:0] s_ctrlport_req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] s_ctrlport_req_data,
  output logic [NUM_PORTS-1:0]        s_ctrlport_resp_ack,
  output logic [STS_W*NUM_PORTS-1:0]  s_ctrlport_resp_status,
  output logic [DATA_W*NUM_PORTS-1:0] s_ctrlport_resp_data,
  output logic                        m_ctrlport_req_wr,
  output logic                        m_ctrlport_req_rd,
  output logic [ADDR_W-1:0]           m_ctrlport_req_addr,
  output logic [DATA_W-1:0]           m_ctrlport_req_data,
  input  logic                        m_ctrlport_resp_ack,
  input  logic [STS_W-1:0]            m_ctrlport_resp_status,
  input  logic [DATA_W-1:0]           m_ctrlport_resp_data
);

  localparam int unsigned    PW        = idx_w(NUM_PORTS);
  localparam int unsigned    CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LOAD   = CW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0]  LAST_PORT = PW'(NUM_PORTS - 1);

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] pending, busy, accept_c, avail_c;
  req_t                 req_q    [NUM_PORTS];
  req_t                 req_in_c [NUM_PORTS];
  req_t                 sel_req_c;
  logic [PW-1:0]        ptr, grant, grant_sel_c;
  logic                 grant_vld_c, issue_c, resp_c, timeout_c, expire_c;
  logic [CW-1:0]        cnt;

  // A strobe is accepted only when the port has nothing queued or outstanding
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_in_c[i].wr   = s_ctrlport_req_wr[i];
      req_in_c[i].addr = s_ctrlport_req_addr[ADDR_W*i +: ADDR_W];
      req_in_c[i].data = s_ctrlport_req_data[DATA_W*i +: DATA_W];
      accept_c[i]      = (s_ctrlport_req_wr[i] | s_ctrlport_req_rd[i]) & ~pending[i] & ~busy[i];
      avail_c[i]       = pending[i] | accept_c[i];
    end
  end

  ctrlport_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_rr_select (
    .pending (avail_c),
    .ptr     (ptr),
    .grant   (grant_sel_c),
    .valid   (grant_vld_c)
  );

  // A strobe arriving while IDLE bypasses the capture register
  always_comb begin
    sel_req_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_sel_c == PW'(i)) sel_req_c = pending[i] ? req_q[i] : req_in_c[i];
    end
  end

  assign expire_c = (cnt == CW'(1));

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_vld_c) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (m_ctrlport_resp_ack)   state_nxt = ST_IDLE;
        else if (expire_c)         state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (m_ctrlport_resp_ack || expire_c) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // An ack coinciding with expiry is treated as a normal response
  always_comb begin
    issue_c   = 1'b0;
    resp_c    = 1'b0;
    timeout_c = 1'b0;
    case (state)
      ST_IDLE: issue_c = grant_vld_c;
      ST_WAIT: begin
        resp_c    = m_ctrlport_resp_ack;
        timeout_c = ~m_ctrlport_resp_ack & expire_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      pending <= '0;
      busy    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) req_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept_c[i]) req_q[i] <= req_in_c[i];
        if (issue_c && grant_sel_c == PW'(i))  pending[i] <= 1'b0;
        else if (accept_c[i])                  pending[i] <= 1'b1;
        if (issue_c && grant_sel_c == PW'(i))                  busy[i] <= 1'b1;
        else if ((resp_c || timeout_c) && grant == PW'(i))     busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      if (issue_c) grant <= grant_sel_c;
      if (resp_c || timeout_c) ptr <= (grant == LAST_PORT) ? '0 : grant + PW'(1);
      if (issue_c || timeout_c) cnt <= TO_LOAD;
      else if (cnt != '0)       cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      m_ctrlport_req_wr   <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      m_ctrlport_req_addr <= '0;
      m_ctrlport_req_data <= '0;
    end else begin
      m_ctrlport_req_wr <= 1'b0;
      m_ctrlport_req_rd <= 1'b0;
      if (issue_c) begin
        m_ctrlport_req_wr   <= sel_req_c.wr;
        m_ctrlport_req_rd   <= ~sel_req_c.wr;
        m_ctrlport_req_addr <= sel_req_c.addr;
        m_ctrlport_req_data <= sel_req_c.data;
      end
    end
  end

  // Only the granted port's response registers change
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      s_ctrlport_resp_ack    <= '0;
      s_ctrlport_resp_status <= {NUM_PORTS{CTRL_STS_OKAY}};
      s_ctrlport_resp_data   <= '0;
    end else begin
      s_ctrlport_resp_ack <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant == PW'(i)) begin
          if (resp_c) begin
            s_ctrlport_resp_ack[i]                    <= 1'b1;
            s_ctrlport_resp_status[STS_W*i +: STS_W]  <= m_ctrlport_resp_status;
            s_ctrlport_resp_data[DATA_W*i +: DATA_W]  <= m_ctrlport_resp_data;
          end else if (timeout_c) begin
            s_ctrlport_resp_ack[i]                    <= 1'b1;
            s_ctrlport_resp_status[STS_W*i +: STS_W]  <= CTRL_STS_CMDERR;
            s_ctrlport_resp_data[DATA_W*i +: DATA_W]  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrlport_spi_arbiter.sv
// Directed self-checking bench for ctrlport_spi_arbiter (2 ports, 16-cycle timeout).
module tb_ctrlport_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_wr, s_rd;
  logic [39:0] s_addr;
  logic [63:0] s_data;
  logic [1:0]  s_ack;
  logic [3:0]  s_sts;
  logic [63:0] s_rdata;
  logic        m_wr, m_rd;
  logic [19:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [1:0]  m_sts;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int acks, issues;

  always #5 clk = ~clk;

  ctrlport_spi_arbiter #(
    .NUM_PORTS      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ctrlport_clk           (clk),
    .ctrlport_rst_n         (rst_n),
    .s_ctrlport_req_wr      (s_wr),
    .s_ctrlport_req_rd      (s_rd),
    .s_ctrlport_req_addr    (s_addr),
    .s_ctrlport_req_data    (s_data),
    .s_ctrlport_resp_ack    (s_ack),
    .s_ctrlport_resp_status (s_sts),
    .s_ctrlport_resp_data   (s_rdata),
    .m_ctrlport_req_wr      (m_wr),
    .m_ctrlport_req_rd      (m_rd),
    .m_ctrlport_req_addr    (m_addr),
    .m_ctrlport_req_data    (m_wdata),
    .m_ctrlport_resp_ack    (m_ack),
    .m_ctrlport_resp_status (m_sts),
    .m_ctrlport_resp_data   (m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int p, input logic w, input logic [19:0] a, input logic [31:0] d);
    s_wr[p]           = w;
    s_rd[p]           = ~w;
    s_addr[20*p +: 20] = a;
    s_data[32*p +: 32] = d;
  endtask

  task automatic clr();
    s_wr = '0; s_rd = '0; s_addr = '0; s_data = '0;
  endtask

  // Drive a one-cycle bridge response in the current cycle
  task automatic bridge_ack(input logic [1:0] st, input logic [31:0] d);
    m_ack = 1'b1; m_sts = st; m_rdata = d;
    tick();
    m_ack = 1'b0; m_sts = '0; m_rdata = '0;
  endtask

  task automatic watch(input int n);
    acks = 0; issues = 0;
    repeat (n) begin
      tick();
      if (s_ack != 2'b00) acks++;
      if (m_wr | m_rd) issues++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr();
    m_ack = 1'b0; m_sts = '0; m_rdata = '0;

    // Reset values
    #3;
    check("rst_s_ack", s_ack, 0);
    check("rst_m_strobes", {m_wr, m_rd}, 0);
    check("rst_m_addr_data", {m_addr, m_wdata}, 0);
    check("rst_s_data_sts", {s_rdata, s_sts}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous reads after reset: port 0 first, port 1 held until port 0 acked
    req(0, 1'b0, 20'h00010, 32'h0); req(1, 1'b0, 20'h00020, 32'h0);
    tick(); clr();
    check("rr_p0_first_rd", {m_wr, m_rd}, 2'b01);
    check("rr_p0_first_addr", m_addr, 20'h00010);
    tick();
    check("rr_single_pulse", {m_wr, m_rd}, 2'b00);
    tick();
    check("rr_p1_held", {m_wr, m_rd}, 2'b00);
    bridge_ack(2'b00, 32'h11111111);
    check("rr_p0_ack", s_ack, 2'b01);
    check("rr_p0_data", s_rdata[31:0], 32'h11111111);
    tick();
    check("rr_p1_second_rd", {m_wr, m_rd}, 2'b01);
    check("rr_p1_second_addr", m_addr, 20'h00020);
    bridge_ack(2'b00, 32'h22222222);
    check("rr_p1_ack", s_ack, 2'b10);
    check("rr_both_data", s_rdata, 64'h22222222_11111111);
    tick();

    // Port 0 write forwarded one cycle after the strobe
    req(0, 1'b1, 20'h08004, 32'hDEADBEEF);
    tick(); clr();
    check("wr_strobe", {m_wr, m_rd}, 2'b10);
    check("wr_addr", m_addr, 20'h08004);
    check("wr_data", m_wdata, 32'hDEADBEEF);
    tick();
    check("wr_pulse_end", {m_wr, m_rd}, 2'b00);
    bridge_ack(2'b00, 32'h0);
    check("wr_ack", s_ack, 2'b01);
    check("wr_resp_data", s_rdata, 64'h22222222_00000000);
    check("wr_resp_sts", s_sts, 4'b0000);
    tick();
    check("wr_ack_pulse_end", s_ack, 2'b00);

    // Repeat of simultaneous reads with pointer at 1: port 1 goes first
    req(0, 1'b0, 20'h00030, 32'h0); req(1, 1'b0, 20'h00040, 32'h0);
    tick(); clr();
    check("rr2_p1_first_addr", {m_rd, m_addr}, {1'b1, 20'h00040});
    bridge_ack(2'b00, 32'h12345678);
    check("rr2_p1_ack", s_ack, 2'b10);
    check("rr2_p1_data_p0_kept", s_rdata, 64'h12345678_00000000);
    check("rr2_sts", s_sts, 4'b0000);
    tick();
    check("rr2_p0_second_addr", {m_rd, m_addr}, {1'b1, 20'h00030});
    bridge_ack(2'b11, 32'hCAFEF00D);
    check("rr2_p0_ack", s_ack, 2'b01);
    check("rr2_p0_data_p1_kept", s_rdata, 64'h12345678_CAFEF00D);
    check("rr2_p0_sts_p1_kept", s_sts, 4'b0011);
    tick();

    // Second strobe from port 0 while in flight is dropped
    req(0, 1'b0, 20'h00050, 32'h0);
    tick(); clr();
    check("drop_issue", {m_rd, m_addr}, {1'b1, 20'h00050});
    tick();
    req(0, 1'b0, 20'h00060, 32'h0);
    tick(); clr();
    tick();
    bridge_ack(2'b00, 32'h00000055);
    check("drop_one_ack", s_ack, 2'b01);
    watch(6);
    check("drop_no_extra_ack", acks, 0);
    check("drop_no_reissue", issues, 0);

    // Timeout: port 1 issued (pointer at 1), port 0 waits behind it
    req(0, 1'b0, 20'h00070, 32'h0); req(1, 1'b0, 20'h00080, 32'h0);
    tick(); clr();
    check("to_issue_p1", {m_rd, m_addr}, {1'b1, 20'h00080});
    watch(15);
    check("to_no_early_ack", acks, 0);
    check("to_no_issue", issues, 0);
    tick();
    check("to_cmderr_ack", s_ack, 2'b10);
    check("to_cmderr_sts", s_sts[3:2], 2'b01);
    check("to_cmderr_data", s_rdata[63:32], 32'h0);
    watch(4);
    check("drain_no_ack", acks, 0);
    check("drain_no_issue", issues, 0);
    bridge_ack(2'b00, 32'h0BAD0BAD);
    check("late_ack_discarded", s_ack, 2'b00);
    check("late_data_discarded", s_rdata[63:32], 32'h0);
    tick();
    check("after_drain_issue_p0", {m_rd, m_addr}, {1'b1, 20'h00070});
    bridge_ack(2'b00, 32'h00000077);
    check("after_drain_ack", s_ack, 2'b01);
    check("after_drain_data", s_rdata[31:0], 32'h00000077);
    tick();

    // Bridge ack on the expiry cycle is a normal response; same port re-requests in its ack cycle
    req(1, 1'b0, 20'h00090, 32'h0);
    tick(); clr();
    check("edge_issue", {m_rd, m_addr}, {1'b1, 20'h00090});
    repeat (15) tick();
    bridge_ack(2'b00, 32'h00000099);
    check("edge_normal_ack", s_ack, 2'b10);
    check("edge_normal_sts", s_sts[3:2], 2'b00);
    check("edge_normal_data", s_rdata[63:32], 32'h00000099);
    req(1, 1'b1, 20'h000A0, 32'h00001234);
    tick(); clr();
    check("ackcycle_accept", {m_wr, m_rd, m_addr}, {2'b10, 20'h000A0});
    bridge_ack(2'b00, 32'h0);
    check("ackcycle_ack", s_ack, 2'b10);
    tick();

    // Asynchronous reset during WAIT
    req(0, 1'b0, 20'h000B0, 32'h0);
    tick(); clr();
    check("rstw_issue", {m_rd, m_addr}, {1'b1, 20'h000B0});
    #2 rst_n = 1'b0;
    #1;
    check("rstw_m_zero", {m_wr, m_rd, m_addr, m_wdata}, 0);
    check("rstw_s_data_zero", s_rdata, 0);
    check("rstw_s_sts_ack_zero", {s_sts, s_ack}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bridge_ack(2'b00, 32'h0000DEAD);
    check("rstw_stale_ack", s_ack, 2'b00);
    watch(3);
    check("rstw_quiet_ack", acks, 0);
    check("rstw_quiet_issue", issues, 0);
    req(1, 1'b0, 20'h000C0, 32'h0);
    tick(); clr();
    check("rstw_fresh_issue", {m_rd, m_addr}, {1'b1, 20'h000C0});
    bridge_ack(2'b00, 32'h0000C0C0);
    check("rstw_fresh_ack", s_ack, 2'b10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
